pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter and consumes the 3-bit next-PC source select that the PC control logic produces from PCOp/ZeroFlag.
- Fetches each instruction from instruction memory through a req/ready handshake and holds it for the datapath.
- When the datapath signals the instruction is done, it applies the selected next-PC and produces the JAL link write.
- Sits between instruction memory, the PC control logic and the register file.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ALIGN_CHECK, 1, 1 = trap on targets with addr[1:0] != 0; 0 = ignore the low bits and force them to 00.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
source  in  3  next-PC select: 000 PC+4, 001 branch, 010 jump, 011 JR, 100 JAL
source_valid  in  1  datapath finished the current instruction; source and operands are stable
branch_offset  in  32  sign-extended immediate, not yet shifted
jump_index  in  26  J-format target field
jr_target  in  32  rs register value for JR
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (equals pc)
imem_ready  in  1  imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  held instruction
instr_valid  out  1  instr is valid for the datapath
pc  out  32  current PC
pc_plus4  out  32  pc + 4, combinational
link_we  out  1  one-cycle $ra write strobe
link_data  out  32  link value
misaligned  out  1  sticky alignment trap flag

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high and overrides every other input in the same cycle, including mid-fetch and mid-exec.
- Reset values: pc=RESET_PC; state=S_FETCH; instr=0; instr_valid=0; imem_req=0; link_we=0; link_data=0; misaligned=0.
- State S_FETCH: imem_req=1 and imem_addr=pc. This includes the first cycle after reset release, so imem_req rises one cycle after reset deasserts.
  - On imem_ready: instr<=imem_rdata, then go to S_EXEC.
  - imem_req stays high until ready arrives. There is no timeout.
- State S_EXEC: instr_valid=1 and imem_req=0.
  - On source_valid, the target is computed:
    - 000: pc+4
    - 001: pc+4 + (branch_offset<<2)
    - 010 and 100: {pc_plus4[31:28], jump_index, 2'b00}
    - 011: jr_target
    - 101–111: treated as 000
  - All adds wrap modulo 2^32.
  - If ALIGN_CHECK=1 and target[1:0] != 0: go to S_HALT, set misaligned=1, leave pc unchanged, and do not assert link_we.
  - If ALIGN_CHECK=0: force the low two bits of the target to 00.
  - Otherwise, on the next edge: pc<=target and state<=S_FETCH.
  - For source=100, on that same edge: link_we<=1 and link_data<=old pc+4. link_we clears on the following edge.
- State S_HALT: instr_valid=0 and imem_req=0. The block stays here until reset.
- Latency:
  - source_valid sampled at edge n gives the new pc and imem_req=1 after edge n, then imem_ready, then instr_valid.
  - Minimum instruction period is 2 cycles, when imem_ready is asserted in the first fetch cycle.
- Ignored inputs:
  - source_valid outside S_EXEC.
  - imem_ready outside S_FETCH.
  - imem_ready and source_valid both high in S_EXEC: only source_valid acts.
- instr_valid falls in the same edge that pc updates.
- pc_plus4 is always pc+4 combinationally, including wrap from 32'hFFFF_FFFC to 0.

Decomposition:
- Shared package pc_pkg holds:
  - source encodings SRC_PC4=3'b000, SRC_BEQ_TAKEN=3'b001, SRC_JUMP=3'b010, SRC_JR=3'b011, SRC_JAL=3'b100;
  - state encodings S_FETCH, S_EXEC, S_HALT.
- One combinational sub-module, pc_next_calc, takes inputs (pc, source, branch_offset, jump_index, jr_target) and outputs (target, misaligned_target). The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset release, imem_ready held high, source=000 on every exec -> imem_addr sequence 0, 4, 8, 12; instr_valid asserted every other cycle.
- pc=0x40, source=001, branch_offset=0xFFFF_FFFE -> next imem_addr=0x3C; branch_offset=0x10 -> 0x84.
- pc=0x1000_0000, source=100, jump_index=0x0000100 -> pc=0x1000_0400, link_we high for exactly 1 cycle, link_data=0x1000_0004.
- source=011, jr_target=0x0000_0202, ALIGN_CHECK=1 -> misaligned=1, state S_HALT, pc holds, imem_req=0 until reset; same case with ALIGN_CHECK=0 -> pc=0x0000_0200.
- imem_ready delayed 3 cycles -> imem_req stays high and imem_addr stable; a source_valid pulse during fetch does not change pc.
- reset asserted in S_EXEC together with source_valid and source=100 -> pc=RESET_PC, link_we=0, instr_valid=0 on the next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// ----------------------------------------------------------------------------
// pc_pkg
// Shared constants for the program-counter sequencer slice:
//   - next-PC source select encodings driven by the PC control logic
//   - sequencer FSM state encodings
//   - helper that forms a J-format jump target
// ----------------------------------------------------------------------------
package pc_pkg;

   // Next-PC source select encodings
   localparam logic [2:0] SRC_PC4       = 3'b000;
   localparam logic [2:0] SRC_BEQ_TAKEN = 3'b001;
   localparam logic [2:0] SRC_JUMP      = 3'b010;
   localparam logic [2:0] SRC_JR        = 3'b011;
   localparam logic [2:0] SRC_JAL       = 3'b100;

   // Sequencer FSM states
   localparam logic [1:0] S_FETCH = 2'b00;
   localparam logic [1:0] S_EXEC  = 2'b01;
   localparam logic [1:0] S_HALT  = 2'b10;

   // J-format target: upper nibble of pc+4, 26-bit index, word aligned
   function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                               input logic [25:0] index);
      jump_target = {pc_plus4[31:28], index, 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_calc.sv
// ----------------------------------------------------------------------------
// pc_next_calc
// Purely combinational next-PC target selection.
// Ports:
//   pc                in  32  current program counter
//   source            in   3  next-PC select (see pc_pkg SRC_*)
//   branch_offset     in  32  sign-extended word offset, not yet shifted
//   jump_index        in  26  J-format target field
//   jr_target         in  32  register value for JR
//   target            out 32  selected next-PC (low bits untouched)
//   misaligned_target out  1  target[1:0] != 0
// ----------------------------------------------------------------------------
module pc_next_calc
   import pc_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [2:0]  source,
   input  logic [31:0] branch_offset,
   input  logic [25:0] jump_index,
   input  logic [31:0] jr_target,
   output logic [31:0] target,
   output logic        misaligned_target
);

   logic [31:0] pc_plus4_s;
   logic [31:0] target_s;

   assign pc_plus4_s = pc + 32'd4;

   // Select the next-PC; unused encodings fall back to sequential flow
   always_comb begin
      target_s = pc_plus4_s;
      case (source)
         SRC_PC4:       target_s = pc_plus4_s;
         SRC_BEQ_TAKEN: target_s = pc_plus4_s + {branch_offset[29:0], 2'b00};
         SRC_JUMP:      target_s = jump_target(pc_plus4_s, jump_index);
         SRC_JR:        target_s = jr_target;
         SRC_JAL:       target_s = jump_target(pc_plus4_s, jump_index);
         default:       target_s = pc_plus4_s;
      endcase
   end

   assign target            = target_s;
   assign misaligned_target = (target_s[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter, fetches each instruction over a req/ready
// handshake, holds it for the datapath and, when the datapath finishes,
// applies the selected next-PC and emits the JAL link write.
// Parameters:
//   RESET_PC     PC value loaded on reset
//   ALIGN_CHECK  1: trap (halt) on unaligned targets; 0: force low bits to 00
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   source, source_valid       next-PC select and "instruction done" strobe
//   branch_offset, jump_index,
//   jr_target                  target operands
//   imem_req, imem_addr        fetch request and address (addr == pc)
//   imem_ready, imem_rdata     fetch response
//   instr, instr_valid         held instruction for the datapath
//   pc, pc_plus4               current PC and pc+4 (combinational)
//   link_we, link_data         one-cycle $ra write for JAL
//   misaligned                 sticky alignment trap flag
// ----------------------------------------------------------------------------
module pc_sequencer
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic        ALIGN_CHECK = 1'b1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  source,
   input  logic        source_valid,
   input  logic [31:0] branch_offset,
   input  logic [25:0] jump_index,
   input  logic [31:0] jr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        link_we,
   output logic [31:0] link_data,
   output logic        misaligned
);

   logic [1:0]  state_r;
   logic [31:0] pc_r;
   logic [31:0] instr_r;
   logic        instr_valid_r;
   logic        imem_req_r;
   logic        link_we_r;
   logic [31:0] link_data_r;
   logic        misaligned_r;

   logic [31:0] raw_target_s;
   logic        raw_misaligned_s;
   logic [31:0] next_pc_s;
   logic        trap_s;

   pc_next_calc u_next_calc (
      .pc                (pc_r),
      .source            (source),
      .branch_offset     (branch_offset),
      .jump_index        (jump_index),
      .jr_target         (jr_target),
      .target            (raw_target_s),
      .misaligned_target (raw_misaligned_s)
   );

   // Apply the alignment policy to the raw target
   always_comb begin
      next_pc_s = raw_target_s;
      trap_s    = 1'b0;
      if (ALIGN_CHECK == 1'b1) begin
         next_pc_s = raw_target_s;
         trap_s    = raw_misaligned_s;
      end else begin
         next_pc_s = {raw_target_s[31:2], 2'b00};
         trap_s    = 1'b0;
      end
   end

   // Sequencer FSM and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= S_FETCH;
         pc_r          <= RESET_PC;
         instr_r       <= 32'h0000_0000;
         instr_valid_r <= 1'b0;
         imem_req_r    <= 1'b0;
         link_we_r     <= 1'b0;
         link_data_r   <= 32'h0000_0000;
         misaligned_r  <= 1'b0;
      end else begin
         // link strobe is single-cycle unless re-armed below
         link_we_r <= 1'b0;
         case (state_r)
            S_FETCH: begin
               // a response only counts once the request is actually out
               if (imem_req_r && imem_ready) begin
                  instr_r       <= imem_rdata;
                  instr_valid_r <= 1'b1;
                  imem_req_r    <= 1'b0;
                  state_r       <= S_EXEC;
               end else begin
                  imem_req_r    <= 1'b1;
               end
            end
            S_EXEC: begin
               if (source_valid) begin
                  if (trap_s) begin
                     misaligned_r  <= 1'b1;
                     instr_valid_r <= 1'b0;
                     imem_req_r    <= 1'b0;
                     state_r       <= S_HALT;
                  end else begin
                     pc_r          <= next_pc_s;
                     instr_valid_r <= 1'b0;
                     imem_req_r    <= 1'b1;
                     state_r       <= S_FETCH;
                     if (source == SRC_JAL) begin
                        link_we_r   <= 1'b1;
                        link_data_r <= pc_plus4;
                     end else begin
                        link_data_r <= link_data_r;
                     end
                  end
               end else begin
                  state_r <= S_EXEC;
               end
            end
            S_HALT: begin
               instr_valid_r <= 1'b0;
               imem_req_r    <= 1'b0;
               state_r       <= S_HALT;
            end
            default: begin
               // corrupted state: stop issuing fetches until reset
               instr_valid_r <= 1'b0;
               imem_req_r    <= 1'b0;
               state_r       <= S_HALT;
            end
         endcase
      end
   end

   assign pc_plus4    = pc_r + 32'd4;
   assign pc          = pc_r;
   assign imem_addr   = pc_r;
   assign imem_req    = imem_req_r;
   assign instr       = instr_r;
   assign instr_valid = instr_valid_r;
   assign link_we     = link_we_r;
   assign link_data   = link_data_r;
   assign misaligned  = misaligned_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer. Two instances share all inputs: dut_a with
// ALIGN_CHECK=1 and dut_b with ALIGN_CHECK=0. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

   logic        clk;
   logic        reset;
   logic [2:0]  source;
   logic        source_valid;
   logic [31:0] branch_offset;
   logic [25:0] jump_index;
   logic [31:0] jr_target;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   logic        req_a, iv_a, lwe_a, mis_a;
   logic [31:0] addr_a, instr_a, pc_a, pc4_a, ld_a;
   logic        req_b, iv_b, lwe_b, mis_b;
   logic [31:0] addr_b, instr_b, pc_b, pc4_b, ld_b;

   int n_cmp = 0;
   int n_err = 0;

   pc_sequencer #(.RESET_PC(32'h0000_0000), .ALIGN_CHECK(1'b1)) dut_a (
      .clk(clk), .reset(reset), .source(source), .source_valid(source_valid),
      .branch_offset(branch_offset), .jump_index(jump_index), .jr_target(jr_target),
      .imem_req(req_a), .imem_addr(addr_a), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instr(instr_a), .instr_valid(iv_a), .pc(pc_a), .pc_plus4(pc4_a),
      .link_we(lwe_a), .link_data(ld_a), .misaligned(mis_a)
   );

   pc_sequencer #(.RESET_PC(32'h0000_0000), .ALIGN_CHECK(1'b0)) dut_b (
      .clk(clk), .reset(reset), .source(source), .source_valid(source_valid),
      .branch_offset(branch_offset), .jump_index(jump_index), .jr_target(jr_target),
      .imem_req(req_b), .imem_addr(addr_b), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instr(instr_b), .instr_valid(iv_b), .pc(pc_b), .pc_plus4(pc4_b),
      .link_we(lwe_b), .link_data(ld_b), .misaligned(mis_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // wait (bounded) for a fetch request, then return one instruction word
   task automatic fetch(input logic [31:0] word);
      for (int i = 0; i < 20 && req_a !== 1'b1; i++) tick();
      check("fetch_req", {31'd0, req_a}, 32'd1);
      imem_ready = 1'b1;
      imem_rdata = word;
      tick();
      imem_ready = 1'b0;
      check("fetch_iv", {31'd0, iv_a}, 32'd1);
      check("fetch_instr", instr_a, word);
   endtask

   task automatic exec(input logic [2:0] src, input logic [31:0] boff,
                       input logic [25:0] jidx, input logic [31:0] jrt);
      source        = src;
      branch_offset = boff;
      jump_index    = jidx;
      jr_target     = jrt;
      source_valid  = 1'b1;
      tick();
      source_valid  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; source = 3'b000; source_valid = 1'b0;
      branch_offset = 32'd0; jump_index = 26'd0; jr_target = 32'd0;
      imem_ready = 1'b0; imem_rdata = 32'd0;
      tick(); tick();

      // reset state
      check("rst_pc", pc_a, 32'h0000_0000);
      check("rst_req", {31'd0, req_a}, 32'd0);
      check("rst_iv", {31'd0, iv_a}, 32'd0);
      check("rst_lwe", {31'd0, lwe_a}, 32'd0);
      check("rst_ld", ld_a, 32'd0);
      check("rst_mis", {31'd0, mis_a}, 32'd0);
      check("rst_instr", instr_a, 32'd0);

      reset = 1'b0;
      tick();
      check("rel_req", {31'd0, req_a}, 32'd1);
      check("rel_addr", addr_a, 32'h0000_0000);

      // sequential flow with ready and source_valid held high
      imem_ready = 1'b1; imem_rdata = 32'hCAFE_0001;
      source = 3'b000; source_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("seq_addr", addr_a, 32'(4 * i));
         check("seq_pc4", pc4_a, 32'(4 * i + 4));
         check("seq_req", {31'd0, req_a}, 32'd1);
         check("seq_iv_lo", {31'd0, iv_a}, 32'd0);
         tick();
         check("seq_iv_hi", {31'd0, iv_a}, 32'd1);
         check("seq_req_lo", {31'd0, req_a}, 32'd0);
         tick();
      end
      imem_ready = 1'b0; source_valid = 1'b0;
      check("seq_end", addr_a, 32'h0000_0010);

      // branch backwards from 0x40
      fetch(32'h1111_0000);
      exec(3'b011, 32'd0, 26'd0, 32'h0000_0040);
      check("jr40", addr_a, 32'h0000_0040);
      fetch(32'h1111_0001);
      exec(3'b001, 32'hFFFF_FFFE, 26'd0, 32'd0);
      check("beq_back", addr_a, 32'h0000_003C);
      check("beq_back_req", {31'd0, req_a}, 32'd1);
      check("beq_back_iv", {31'd0, iv_a}, 32'd0);

      // branch forwards from 0x40
      fetch(32'h1111_0002);
      exec(3'b011, 32'd0, 26'd0, 32'h0000_0040);
      fetch(32'h1111_0003);
      exec(3'b001, 32'h0000_0010, 26'd0, 32'd0);
      check("beq_fwd", addr_a, 32'h0000_0084);

      // JAL from 0x1000_0000
      fetch(32'h2222_0000);
      exec(3'b011, 32'd0, 26'd0, 32'h1000_0000);
      fetch(32'h2222_0001);
      exec(3'b100, 32'd0, 26'h0000100, 32'd0);
      check("jal_pc", pc_a, 32'h1000_0400);
      check("jal_lwe", {31'd0, lwe_a}, 32'd1);
      check("jal_ld", ld_a, 32'h1000_0004);
      tick();
      check("jal_lwe_clr", {31'd0, lwe_a}, 32'd0);
      check("jal_ld_hold", ld_a, 32'h1000_0004);

      // delayed ready; source_valid during fetch is ignored
      source = 3'b011; jr_target = 32'h0000_0500; source_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("wait_req", {31'd0, req_a}, 32'd1);
         check("wait_addr", addr_a, 32'h1000_0400);
         tick();
      end
      check("wait_pc", pc_a, 32'h1000_0400);
      source_valid = 1'b0;
      imem_ready = 1'b1; imem_rdata = 32'h3333_0000;
      tick();
      imem_ready = 1'b0;
      check("late_iv", {31'd0, iv_a}, 32'd1);
      check("late_instr", instr_a, 32'h3333_0000);

      // reset in EXEC beats a JAL completion
      reset = 1'b1; source = 3'b100; jump_index = 26'h0000200; source_valid = 1'b1;
      tick();
      check("rx_pc", pc_a, 32'h0000_0000);
      check("rx_lwe", {31'd0, lwe_a}, 32'd0);
      check("rx_iv", {31'd0, iv_a}, 32'd0);
      check("rx_req", {31'd0, req_a}, 32'd0);
      reset = 1'b0; source_valid = 1'b0;
      tick();

      // misaligned JR target
      fetch(32'h4444_0000);
      exec(3'b011, 32'd0, 26'd0, 32'h0000_0202);
      check("mis_flag", {31'd0, mis_a}, 32'd1);
      check("mis_pc", pc_a, 32'h0000_0000);
      check("mis_req", {31'd0, req_a}, 32'd0);
      check("mis_iv", {31'd0, iv_a}, 32'd0);
      check("mis_lwe", {31'd0, lwe_a}, 32'd0);
      check("noalign_pc", pc_b, 32'h0000_0200);
      check("noalign_flag", {31'd0, mis_b}, 32'd0);
      imem_ready = 1'b1; source_valid = 1'b1; source = 3'b000;
      tick(); tick(); tick();
      check("halt_pc", pc_a, 32'h0000_0000);
      check("halt_req", {31'd0, req_a}, 32'd0);
      check("halt_iv", {31'd0, iv_a}, 32'd0);
      check("halt_mis", {31'd0, mis_a}, 32'd1);
      imem_ready = 1'b0; source_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("halt_rst_mis", {31'd0, mis_a}, 32'd0);
      tick();
      check("halt_rst_req", {31'd0, req_a}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
